// File: rtl/result_streamer.sv
// ---------------------------------------------------------------------------
// result_streamer: captures the result bus after a settle delay, then streams
// it out LSB byte first over 8-bit valid/ready with a trailing XOR checksum.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module result_streamer #(
  parameter int RESULT_W      = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [RESULT_W-1:0] result_in,
  output logic [7:0]          byte_out,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic                byte_last,
  output logic                busy,
  output logic                done,
  output logic [7:0]          frame_count
);

  localparam int NUM_BYTES = RESULT_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SEND   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          settle_cnt_q, settle_cnt_d;
  logic [RESULT_W-1:0] shadow_q, shadow_d;
  logic [7:0]          checksum_q, checksum_d;
  logic [3:0]          index_q, index_d;
  logic [7:0]          byte_out_q, byte_out_d;
  logic                byte_valid_q, byte_valid_d;
  logic                byte_last_q, byte_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [7:0]          frame_count_q, frame_count_d;

  logic [7:0]          result_xor;
  logic [3:0]          next_index;
  logic [7:0]          next_shadow_byte;

  always_comb begin
    result_xor = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      result_xor = result_xor ^ result_in[b*8 +: 8];
    end
  end

  // Byte presented after a transfer; the output is registered, so it is
  // looked up from the index the next cycle will hold.
  always_comb begin
    next_index       = index_q + 4'd1;
    next_shadow_byte = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (next_index == 4'(b)) begin
        next_shadow_byte = shadow_q[b*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    shadow_d      = shadow_q;
    checksum_d    = checksum_q;
    index_d       = index_q;
    byte_out_d    = byte_out_q;
    byte_valid_d  = byte_valid_q;
    byte_last_d   = byte_last_q;
    done_d        = 1'b0;
    frame_count_d = frame_count_q;

    case (state_q)
      IDLE: begin
        byte_valid_d = 1'b0;
        byte_last_d  = 1'b0;
        byte_out_d   = '0;
        if (start) begin
          state_d      = SETTLE;
          settle_cnt_d = 4'(SETTLE_CYCLES);
        end
      end
      SETTLE: begin
        if (settle_cnt_q != 4'd0) begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end else begin
          shadow_d     = result_in;
          checksum_d   = result_xor;
          index_d      = 4'd0;
          byte_out_d   = result_in[7:0];
          byte_valid_d = 1'b1;
          byte_last_d  = 1'b0;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (byte_ready) begin
          if (index_q == 4'(NUM_BYTES)) begin
            state_d       = IDLE;
            index_d       = 4'd0;
            byte_out_d    = '0;
            byte_valid_d  = 1'b0;
            byte_last_d   = 1'b0;
            done_d        = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
          end else begin
            index_d = next_index;
            if (next_index == 4'(NUM_BYTES)) begin
              byte_out_d  = checksum_q;
              byte_last_d = 1'b1;
            end else begin
              byte_out_d  = next_shadow_byte;
              byte_last_d = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      settle_cnt_q  <= '0;
      shadow_q      <= '0;
      checksum_q    <= '0;
      index_q       <= '0;
      byte_out_q    <= '0;
      byte_valid_q  <= 1'b0;
      byte_last_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      shadow_q      <= shadow_d;
      checksum_q    <= checksum_d;
      index_q       <= index_d;
      byte_out_q    <= byte_out_d;
      byte_valid_q  <= byte_valid_d;
      byte_last_q   <= byte_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign byte_out    = byte_out_q;
  assign byte_valid  = byte_valid_q;
  assign byte_last   = byte_last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_count = frame_count_q;

endmodule

`default_nettype wire
